// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Sits after the orGate16 zero-detect tree in the in-order execute stage.
//   It holds the architectural NZCV register and resolves B.cond, CBZ and
//   CBNZ taken decisions through a two-stage valid/ready pipeline (S1 eval,
//   S2 output register) feeding the fetch-redirect logic.
//
//   Optional build macro: FLAG_BRANCH_STATS_EN adds the saturating 16-bit
//   br_count / taken_count statistics outputs.
//
//   Handshake: a transfer happens on a rising clk edge where the producer's
//   valid and the consumer's ready are both high. A producer holds valid and
//   payload stable until that edge. in_ready is built only from internal
//   state and out_ready, never from in_valid.
//
//   WIDTH must be a multiple of 16; one nz_chunks bit per 16-bit chunk.
module flag_branch_unit #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [WIDTH/16-1:0]   nz_chunks,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic                  set_flags,
    input  logic [1:0]            br_op,
    input  logic [3:0]            cond,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_taken,
    output logic [3:0]            out_flags,
    output logic [3:0]            flags
`ifdef FLAG_BRANCH_STATS_EN
    ,
    output logic [15:0]           br_count,
    output logic [15:0]           taken_count
`endif
);

    localparam int NCHUNK = WIDTH / 16;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_BCOND = 2'b01,
        BR_CBZ   = 2'b10,
        BR_CBNZ  = 2'b11
    } br_op_e;

    // ARM condition codes, indexed by the 4-bit cond field.
    typedef enum logic [3:0] {
        CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
        CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
        CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
        CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
    } cond_e;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // S1 holds only what evaluation needs: the sign bit of the result is the
    // only bit of alu_result that matters, zero comes from the chunk ORs.
    logic              r_s1_valid;
    logic              r_s1_n;
    logic [NCHUNK-1:0] r_s1_nz_chunks;
    logic              r_s1_c;
    logic              r_s1_v;
    logic              r_s1_set_flags;
    br_op_e            r_s1_br_op;
    cond_e             r_s1_cond;

    logic              r_s2_valid;
    logic              r_s2_taken;
    logic [3:0]        r_s2_flags;
    logic [3:0]        r_flags;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic              w_advance;
    logic              w_accept;
    logic              w_s1_move;
    logic              w_s2_drain;

    // Lower result bits are intentionally ignored; the zero test uses the
    // orGate16 outputs instead of a second WIDTH-wide reduction.
    logic              w_unused_result;
    assign w_unused_result = ^alu_result[WIDTH-2:0];

    assign w_advance  = ~r_s2_valid | out_ready;
    assign in_ready   = ~r_s1_valid | w_advance;
    assign w_accept   = in_valid & in_ready;
    assign w_s1_move  = r_s1_valid & w_advance;
    assign w_s2_drain = r_s2_valid & out_ready;

    // ------------------------------------------------------------------
    // S1 evaluation
    // ------------------------------------------------------------------
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_nzcv;
    logic              w_cond_pass;
    logic              w_taken;

    // Flags produced by the op sitting in S1.
    always_comb begin
        w_n    = r_s1_n;
        w_z    = ~|r_s1_nz_chunks;
        w_c    = r_s1_c;
        w_v    = r_s1_v;
        w_nzcv = {w_n, w_z, w_c, w_v};
    end

    // Condition check for BCOND, always against the committed flag register
    // (this op's own flag write lands only as it leaves S1).
    always_comb begin
        logic f_n;
        logic f_z;
        logic f_c;
        logic f_v;
        f_n = r_flags[3];
        f_z = r_flags[2];
        f_c = r_flags[1];
        f_v = r_flags[0];
        w_cond_pass = 1'b0;
        case (r_s1_cond)
            CC_EQ:   w_cond_pass = f_z;
            CC_NE:   w_cond_pass = ~f_z;
            CC_CS:   w_cond_pass = f_c;
            CC_CC:   w_cond_pass = ~f_c;
            CC_MI:   w_cond_pass = f_n;
            CC_PL:   w_cond_pass = ~f_n;
            CC_VS:   w_cond_pass = f_v;
            CC_VC:   w_cond_pass = ~f_v;
            CC_HI:   w_cond_pass = f_c & ~f_z;
            CC_LS:   w_cond_pass = ~f_c | f_z;
            CC_GE:   w_cond_pass = (f_n == f_v);
            CC_LT:   w_cond_pass = (f_n != f_v);
            CC_GT:   w_cond_pass = ~f_z & (f_n == f_v);
            CC_LE:   w_cond_pass = f_z | (f_n != f_v);
            CC_AL:   w_cond_pass = 1'b1;
            CC_NV:   w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Taken decision per branch kind; CBZ/CBNZ test this op's own result.
    always_comb begin
        w_taken = 1'b0;
        case (r_s1_br_op)
            BR_NONE:  w_taken = 1'b0;
            BR_BCOND: w_taken = w_cond_pass;
            BR_CBZ:   w_taken = w_z;
            BR_CBNZ:  w_taken = ~w_z;
            default:  w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // S1: capture on accept, empty when its op moves on with nothing new.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_n         <= 1'b0;
            r_s1_nz_chunks <= '0;
            r_s1_c         <= 1'b0;
            r_s1_v         <= 1'b0;
            r_s1_set_flags <= 1'b0;
            r_s1_br_op     <= BR_NONE;
            r_s1_cond      <= CC_EQ;
        end else if (w_accept) begin
            r_s1_valid     <= 1'b1;
            r_s1_n         <= alu_result[WIDTH-1];
            r_s1_nz_chunks <= nz_chunks;
            r_s1_c         <= alu_carry;
            r_s1_v         <= alu_overflow;
            r_s1_set_flags <= set_flags;
            r_s1_br_op     <= br_op_e'(br_op);
            r_s1_cond      <= cond_e'(cond);
        end else if (w_advance) begin
            r_s1_valid     <= 1'b0;
        end
    end

    // S2: load the decision when S1 moves; otherwise empty on drain, hold on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_taken <= 1'b0;
            r_s2_flags <= 4'b0000;
        end else if (w_s1_move) begin
            r_s2_valid <= 1'b1;
            r_s2_taken <= w_taken;
            r_s2_flags <= w_nzcv;
        end else if (w_s2_drain) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Architectural NZCV: written only as a flag-setting op leaves S1, so
    // writes happen in program order and the next op in S1 sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_s1_move && r_s1_set_flags) begin
            r_flags <= w_nzcv;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_taken = r_s2_taken;
    assign out_flags = r_s2_flags;
    assign flags     = r_flags;

`ifdef FLAG_BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Branch statistics
    // ------------------------------------------------------------------
    logic        r_s2_is_br;
    logic [15:0] r_br_count;
    logic [15:0] r_taken_count;

    // Remember whether the op in S2 is a branch so it can be counted on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_is_br <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_is_br <= (r_s1_br_op != BR_NONE);
        end
    end

    // Saturating counters bumped as a branch decision is handed downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_br_count    <= 16'h0000;
            r_taken_count <= 16'h0000;
        end else if (w_s2_drain && r_s2_is_br) begin
            if (r_br_count != 16'hFFFF) begin
                r_br_count <= r_br_count + 16'h0001;
            end
            if (r_s2_taken && (r_taken_count != 16'hFFFF)) begin
                r_taken_count <= r_taken_count + 16'h0001;
            end
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios from the test plan plus a
// randomized run scored against an in-order behavioural model.
module tb_flag_branch_unit;

    localparam int W   = 64;
    localparam int NCH = W / 16;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   alu_result;
    logic [NCH-1:0] nz_chunks;
    logic           alu_carry;
    logic           alu_overflow;
    logic           set_flags;
    logic [1:0]     br_op;
    logic [3:0]     cond;
    logic           out_valid;
    logic           out_ready;
    logic           out_taken;
    logic [3:0]     out_flags;
    logic [3:0]     flags;
`ifdef FLAG_BRANCH_STATS_EN
    logic [15:0]    br_count;
    logic [15:0]    taken_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: committed flags and expected {taken, nzcv}.
    logic [3:0] m_flags;
    logic [4:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    flag_branch_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .nz_chunks    (nz_chunks),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .set_flags    (set_flags),
        .br_op        (br_op),
        .cond         (cond),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_taken    (out_taken),
        .out_flags    (out_flags),
        .flags        (flags)
`ifdef FLAG_BRANCH_STATS_EN
        ,
        .br_count     (br_count),
        .taken_count  (taken_count)
`endif
    );

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nz_chunks is derived from the result the same way the orGate16 tree does.
    task automatic drive_op(input bit v, input logic [W-1:0] res, input bit c,
                            input bit ov, input bit sf, input logic [1:0] bop,
                            input logic [3:0] cd);
        in_valid     = v;
        alu_result   = res;
        for (int i = 0; i < NCH; i++) nz_chunks[i] = |res[16*i +: 16];
        alu_carry    = c;
        alu_overflow = ov;
        set_flags    = sf;
        br_op        = bop;
        cond         = cd;
    endtask

    task automatic drive_idle();
        drive_op(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic rand_op(output logic [W-1:0] res, output bit c, output bit ov,
                           output bit sf, output logic [1:0] bop, output logic [3:0] cd);
        int sel;
        int k;
        sel = $urandom_range(0, 9);
        k   = $urandom_range(0, NCH - 1);
        if (sel < 3) res = '0;
        else if (sel < 6) res = W'($urandom_range(1, 16'hFFFF)) << (16 * k);
        else res = {$urandom, $urandom};
        c   = 1'($urandom_range(0, 1));
        ov  = 1'($urandom_range(0, 1));
        sf  = ($urandom_range(0, 9) < 4);
        bop = 2'($urandom_range(0, 3));
        cd  = 4'($urandom_range(0, 15));
    endtask

    // ------------------------------------------------------------------
    // Reference model (architectural rules, evaluated in program order)
    // ------------------------------------------------------------------
    function automatic bit cond_pass(input logic [3:0] cd, input logic [3:0] f);
        bit n;
        bit z;
        bit c;
        bit v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Returns {taken, nzcv} for one op and commits its flag write.
    function automatic logic [4:0] model_op(input logic [W-1:0] res, input bit c,
                                            input bit ov, input bit sf,
                                            input logic [1:0] bop, input logic [3:0] cd);
        logic [3:0] nzcv;
        bit taken;
        nzcv = {res[W-1], (res == '0), c, ov};
        case (bop)
            2'b01:   taken = cond_pass(cd, m_flags);
            2'b10:   taken = (res == '0);
            2'b11:   taken = (res != '0);
            default: taken = 1'b0;
        endcase
        if (sf) m_flags = nzcv;
        return {taken, nzcv};
    endfunction

    // ------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        drive_idle();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        total++; if (out_taken !== 1'b0 || out_flags !== 4'b0000) begin
            bad++; $display("FAIL reset_outputs got=%b/%b exp=0/0000", out_taken, out_flags);
        end
        // Put a negative flag-setting op into S2, then reset mid-cycle.
        drive_op(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
        tick();
        drive_op(1'b1, 64'h0000_0000_0000_0005, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0);
        tick();
        drive_idle();
        total++; if (flags !== 4'b1000 || out_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_state got=flags %b valid %b exp=1000 1", flags, out_valid);
        end
        #3;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid got=%b exp=0", out_valid); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL async_reset_flags got=%b exp=0000", flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_taken !== 1'b0 || out_flags !== 4'b0000) begin
            bad++; $display("FAIL async_reset_outputs got=%b/%b exp=0/0000", out_taken, out_flags);
        end
        tick();
        reset = 1'b0;
        tick();
        m_flags = 4'b0000;
    endtask

    task automatic test_zero_then_branch();
        out_ready = 1'b1;
        // SUBS with zero result, C=1, V=0
        drive_op(1'b1, '0, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0);
        tick();
        // B.EQ
        drive_op(1'b1, 64'h0000_0000_0000_0010, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        tick();
        drive_idle();
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL subs_flags got=%b exp=0110", flags); end
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_flags !== 4'b0110) begin
            bad++; $display("FAIL subs_out got=%b/%b/%b exp=1/0/0110", out_valid, out_taken, out_flags);
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_flags !== 4'b0000) begin
            bad++; $display("FAIL beq_out got=%b/%b/%b exp=1/1/0000", out_valid, out_taken, out_flags);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zb_drain got=%b exp=0", out_valid); end
        m_flags = 4'b0110;
    endtask

    task automatic test_cbz_chunks();
        out_ready = 1'b1;
        drive_op(1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0);
        total++; if (nz_chunks !== 4'b1000) begin bad++; $display("FAIL chunk_pattern got=%b exp=1000", nz_chunks); end
        tick();
        drive_op(1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0);
        tick();
        drive_idle();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_flags !== 4'b0000) begin
            bad++; $display("FAIL cbz_out got=%b/%b/%b exp=1/0/0000", out_valid, out_taken, out_flags);
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b1) begin
            bad++; $display("FAIL cbnz_out got=%b/%b exp=1/1", out_valid, out_taken);
        end
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL cb_flags_kept got=%b exp=0110", flags); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_op(1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0);                       // CBZ, taken
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", in_ready); end
        tick();
        drive_op(1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd0);                       // CBNZ, not taken
        tick();
        drive_op(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 2'b01, 4'd14); // AL, taken
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_flags !== 4'b0100 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%b/%b exp=1/1/0100/0", i, out_valid, out_taken, out_flags, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        drive_idle();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b0 || out_flags !== 4'b0100) begin
            bad++; $display("FAIL bp_op2 got=%b/%b/%b exp=1/0/0100", out_valid, out_taken, out_flags);
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_flags !== 4'b1000) begin
            bad++; $display("FAIL bp_op3 got=%b/%b/%b exp=1/1/1000", out_valid, out_taken, out_flags);
        end
        tick();
        total++; if (out_valid !== 1'b0 || flags !== 4'b0110) begin
            bad++; $display("FAIL bp_end got=%b/%b exp=0/0110", out_valid, flags);
        end
    endtask

    task automatic test_signed_conds();
        logic [3:0] cds [5];
        bit         exp_t [5];
        cds   = '{4'd0, 4'd12, 4'd11, 4'd13, 4'd15};
        exp_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i == 0) drive_op(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 2'b00, 4'd0);
            else if (i < 5) drive_op(1'b1, 64'h1, 1'b0, 1'b0, 1'b0, 2'b01, cds[i]);
            else drive_idle();
            tick();
            if (i >= 1) begin
                total++; if (out_valid !== 1'b1 || out_taken !== exp_t[i-1]) begin
                    bad++; $display("FAIL signed_cond idx=%0d cond=%0d got=%b/%b exp=1/%b", i-1, cds[i-1], out_valid, out_taken, exp_t[i-1]);
                end
            end
        end
        drive_idle();
        total++; if (flags !== 4'b1001) begin bad++; $display("FAIL signed_flags got=%b exp=1001", flags); end
        tick();
    endtask

    task automatic test_reset_pending();
        out_ready = 1'b1;
        drive_op(1'b1, '0, 1'b1, 1'b1, 1'b1, 2'b00, 4'd0);
        tick();
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        total++; if (flags !== 4'b0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL pend_reset got=%b/%b/%b exp=0000/0/1", flags, out_valid, in_ready);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || flags !== 4'b0000) begin
                bad++; $display("FAIL pend_after cyc=%0d got=%b/%b exp=0/0000", i, out_valid, flags);
            end
        end
        m_flags = 4'b0000;
    endtask

    task automatic test_random();
        logic [W-1:0] res;
        bit           c;
        bit           ov;
        bit           sf;
        logic [1:0]   bop;
        logic [3:0]   cd;
        logic [4:0]   e;
        int           budget;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rand_op(res, c, ov, sf, bop, cd);
            drive_op(($urandom_range(0, 9) < 7), res, c, ov, sf, bop, cd);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected cyc=%0d got=%b/%b exp=none", cyc, out_taken, out_flags);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_taken, out_flags} !== e) begin
                        bad++; $display("FAIL rand_out cyc=%0d got=%b/%b exp=%b/%b", cyc, out_taken, out_flags, e[4], e[3:0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_op(res, c, ov, sf, bop, cd));
            tick();
        end
        drive_idle();
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if ({out_taken, out_flags} !== e) begin
                    bad++; $display("FAIL rand_drain got=%b/%b exp=%b/%b", out_taken, out_flags, e[4], e[3:0]);
                end
            end
            tick();
            budget++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_timeout left=%0d exp=0", exp_q.size()); end
        total++; if (out_valid !== 1'b0 || flags !== m_flags) begin
            bad++; $display("FAIL rand_final got=%b/%b exp=0/%b", out_valid, flags, m_flags);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        bit           c;
        bit           ov;
        bit           sf;
        logic [1:0]   bop;
        logic [3:0]   cd;
        logic [4:0]   e;
        out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= 9; i++) begin
            if (i < 8) begin
                rand_op(res, c, ov, sf, bop, cd);
                if (i % 2 == 1) bop = 2'b01;  // alternate flag writers with B.cond readers
                else sf = 1'b1;
                drive_op(1'b1, res, c, ov, sf, bop, cd);
                exp_q.push_back(model_op(res, c, ov, sf, bop, cd));
                #1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, in_ready); end
            end else begin
                drive_idle();
            end
            tick();
            if (i >= 1 && i <= 8) begin
                e = exp_q.pop_front();
                total++; if (out_valid !== 1'b1 || {out_taken, out_flags} !== e) begin
                    bad++; $display("FAIL b2b_out idx=%0d got=%b/%b/%b exp=1/%b/%b", i-1, out_valid, out_taken, out_flags, e[4], e[3:0]);
                end
            end
        end
        total++; if (out_valid !== 1'b0 || flags !== m_flags) begin
            bad++; $display("FAIL b2b_end got=%b/%b exp=0/%b", out_valid, flags, m_flags);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        m_flags = 4'b0000;
        test_reset();
        test_zero_then_branch();
        test_cbz_chunks();
        test_backpressure();
        test_signed_conds();
        test_reset_pending();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound in case the DUT wedges a wait.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
